// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side adapter for a fixed-latency synchronous FIFO. Issues fifo_rd_en
//   whenever the FIFO has data and a skid-buffer slot is guaranteed for the word,
//   tracks reads in flight with a valid pipe, captures returning data into the
//   skid buffer and presents it as a valid/ready stream.
//
// Ports
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO read strobe, one word per asserted cycle
//   fifo_data   FIFO read data, valid RD_LATENCY clocks after fifo_rd_en
//   m_valid     output word available
//   m_ready     consumer accepts the word
//   m_data      output word
//   busy        reads in flight or buffer non-empty
//   rd_count    words delivered on the stream, wraps at 2^16
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 2,
    parameter int SKID_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [15:0]           rd_count
);
    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = $clog2(SKID_DEPTH + 1);
    // wide enough to hold inflight + buf_cnt without overflow
    localparam int SW = $clog2(RD_LATENCY + SKID_DEPTH + 1);

    logic [RD_LATENCY-1:0] vpipe_q, vpipe_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         buf_cnt_q, buf_cnt_d;
    logic [15:0]           rd_count_q, rd_count_d;
    logic [DATA_WIDTH-1:0] skid_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] skid_d [SKID_DEPTH];

    logic [SW-1:0] inflight;
    logic          credit_ok;
    logic          push;
    logic          pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + SW'(vpipe_q[i]);
        end
    end

    // Credit uses the registered count only: a slot freed by this cycle's pop
    // becomes usable next cycle, keeping the read strobe off the m_ready path.
    assign credit_ok  = (inflight + SW'(buf_cnt_q)) < SW'(SKID_DEPTH);
    assign fifo_rd_en = rst_n && !fifo_empty && credit_ok;

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign vpipe_d = fifo_rd_en;
        end else begin : g_latn
            assign vpipe_d = {vpipe_q[RD_LATENCY-2:0], fifo_rd_en};
        end
    endgenerate

    assign push     = vpipe_q[RD_LATENCY-1];
    assign m_valid  = (buf_cnt_q != '0);
    assign m_data   = skid_q[rptr_q];
    assign pop      = m_valid && m_ready;
    assign busy     = (inflight != '0) || m_valid;
    assign rd_count = rd_count_q;

    always_comb begin
        skid_d     = skid_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        buf_cnt_d  = buf_cnt_q;
        rd_count_d = rd_count_q;
        if (push) begin
            skid_d[wptr_q] = fifo_data;
            wptr_d         = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d     = rptr_q + PW'(1);
            rd_count_d = rd_count_q + 16'd1;
        end
        case ({push, pop})
            2'b10:   buf_cnt_d = buf_cnt_q + CW'(1);
            2'b01:   buf_cnt_d = buf_cnt_q - CW'(1);
            default: buf_cnt_d = buf_cnt_q;
        endcase
    end

    // Buffer storage is reset too so m_data reads 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            buf_cnt_q  <= '0;
            rd_count_q <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_q[i] <= '0;
            end
        end else begin
            vpipe_q    <= vpipe_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            buf_cnt_q  <= buf_cnt_d;
            rd_count_q <= rd_count_d;
            skid_q     <= skid_d;
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
//   Bench for fifo_rd_stream with a behavioural fixed-latency FIFO in front and
//   a scoreboard of words popped from that FIFO, checked against the stream.
module tb_fifo_rd_stream;
    localparam int DW  = 8;
    localparam int LAT = 2;
    localparam int SD  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          busy;
    logic [15:0]   rd_count;

    fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(LAT), .SKID_DEPTH(SD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .rd_count   (rd_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src   [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] dp    [LAT];
    assign fifo_data = dp[LAT-1];

    int          n_vec = 0;
    int          n_err = 0;
    int          issued = 0;
    int          popped = 0;
    logic [15:0] cnt_model = 16'd0;
    logic        rd_en_s = 1'b0;
    int          ready_mode = 0;

    typedef struct {
        logic        rdy;
        logic        rd_en;
        logic        vld;
        logic [7:0]  data;
        logic        bsy;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // FIFO model and m_ready driver: everything changes 1 time unit after the edge.
    initial begin
        for (int k = 0; k < LAT; k++) dp[k] = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = LAT - 1; k > 0; k--) dp[k] = dp[k-1];
            dp[0] = '0;
            if (rst_n && rd_en_s) begin
                chk("rd_nonempty", 32'(src.size() != 0), 32'd1);
                if (src.size() != 0) begin
                    dp[0] = src.pop_front();
                    exp_q.push_back(dp[0]);
                end
            end
            fifo_empty = (src.size() == 0);
            case (ready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Stream monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                rd_en_s = fifo_rd_en;
                chk("occupancy", 32'((issued - popped + int'(fifo_rd_en)) <= SD), 32'd1);
                chk("busy", 32'(busy), 32'((issued - popped) != 0));
                chk("rd_count", 32'(rd_count), 32'(cnt_model));
                if (m_valid) begin
                    chk("valid_has_exp", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) chk("m_data", 32'(m_data), 32'(exp_q[0]));
                    if (m_ready) begin
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        popped++;
                        cnt_model = cnt_model + 16'd1;
                    end
                end
                if (fifo_rd_en) issued++;
            end else begin
                rd_en_s = 1'b0;
            end
        end
    end

    task automatic clear_model();
        src.delete();
        exp_q.delete();
        issued    = 0;
        popped    = 0;
        cnt_model = 16'd0;
        rd_en_s   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_rd_en"},    32'(fifo_rd_en), 32'd0);
        chk({nm, "_m_valid"},  32'(m_valid),    32'd0);
        chk({nm, "_m_data"},   32'(m_data),     32'd0);
        chk({nm, "_busy"},     32'(busy),       32'd0);
        chk({nm, "_rd_count"}, 32'(rd_count),   32'd0);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs(nm);
        clear_model();
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (src.size() == 0 && exp_q.size() == 0 && !busy) done = 1'b1;
        end
        chk(nm, 32'(done), 32'd1);
    endtask

    initial begin
        int t_rd;
        int t_v;
        int n;
        // single-word sequence: {m_ready, rd_en, m_valid, m_data, busy, rd_count}
        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd1036};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd1036};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd1036};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 16'd1036};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 16'd1036};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1037};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1037};

        // power-on reset
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("por");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // streaming 0x01..0x10 with m_ready held high
        ready_mode = 1;
        for (int i = 1; i <= 16; i++) src.push_back(8'(i));
        t_rd = -1;
        t_v  = -1;
        for (int i = 0; i < 60 && t_v < 0; i++) begin
            @(negedge clk);
            if (fifo_rd_en && t_rd < 0) t_rd = i;
            if (m_valid) t_v = i;
        end
        chk("stream_first_valid_found", 32'(t_v >= 0), 32'd1);
        chk("stream_latency", 32'(t_v - t_rd), 32'(LAT + 1));
        chk("stream_word_1", 32'({m_valid, m_data}), 32'h101);
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("stream_word_%0d", k), 32'({m_valid, m_data}), 32'(9'h100 | k));
        end
        wait_idle("stream_drain", 50);
        chk("stream_rd_count", 32'(rd_count), 32'd16);

        // back-pressure with a deep FIFO
        ready_mode = 0;
        for (int i = 0; i < 20; i++) src.push_back(8'(8'h30 + i));
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n = n + int'(fifo_rd_en);
        end
        chk("bp_reads", 32'(n), 32'd4);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_busy", 32'(busy), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_data", 32'(m_data), 32'h30);
            chk("bp_no_rd", 32'(fifo_rd_en), 32'd0);
        end
        ready_mode = 1;
        wait_idle("bp_drain", 200);
        chk("bp_rd_count", 32'(rd_count), 32'd36);

        // random stall over 1000 words
        ready_mode = 2;
        for (int i = 0; i < 1000; i++) src.push_back(8'($urandom));
        wait_idle("rand_drain", 5000);
        chk("rand_rd_count", 32'(rd_count), 32'd1036);

        // single word 0xA5, cycle by cycle
        src.push_back(8'hA5);
        for (int i = 0; i < 7; i++) begin
            ready_mode = int'(tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("sw%0d_rd_en", i),    32'(fifo_rd_en), 32'(tbl[i].rd_en));
            chk($sformatf("sw%0d_m_valid", i),  32'(m_valid),    32'(tbl[i].vld));
            chk($sformatf("sw%0d_busy", i),     32'(busy),       32'(tbl[i].bsy));
            chk($sformatf("sw%0d_rd_count", i), 32'(rd_count),   32'(tbl[i].cnt));
            if (tbl[i].vld) chk($sformatf("sw%0d_m_data", i), 32'(m_data), 32'(tbl[i].data));
        end

        // reset mid-stream: nothing stale may surface afterwards
        ready_mode = 1;
        for (int i = 0; i < 30; i++) src.push_back(8'(8'h50 + i));
        repeat (8) @(negedge clk);
        do_reset("mid_rst");
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_no_valid", 32'(m_valid), 32'd0);
        end
        for (int i = 0; i < 5; i++) src.push_back(8'(8'hC0 + i));
        wait_idle("post_rst_drain", 100);
        chk("post_rst_rd_count", 32'(rd_count), 32'd5);

        // 65537 words: rd_count wraps to 1, pointers wrap many times
        do_reset("wrap_rst");
        ready_mode = 1;
        for (int i = 0; i < 65537; i++) src.push_back(8'(i * 7));
        wait_idle("wrap_drain", 66000);
        chk("wrap_rd_count", 32'(rd_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
